// File: rtl/router_pkt_rx.sv
// Destination-side packet receiver: drains a router_fifo, parses header/payload/parity
// framing, streams payload through a 2-entry skid buffer and keeps good/bad packet counters.
module router_pkt_rx #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_read_enb,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             trunc_err,
  output logic [CNT_W-1:0] pkt_good_cnt,
  output logic [CNT_W-1:0] pkt_err_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_PAR} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } entry_t;

  state_t          state, state_nxt;
  logic            inflight;
  logic [1:0]      occ;
  logic            wr_ptr, rd_ptr;
  entry_t          skid [2];
  logic [TMR_W-1:0] timer;
  logic [5:0]      cnt;
  logic [7:0]      par;
  logic            first;

  logic arrival, push, pop, timeout_hit, parity_bad;

  // Every accepted read, header and parity included, holds a credit until it arrives.
  assign fifo_read_enb = !fifo_empty && ((3'(occ) + 3'(inflight)) < 3'd2);
  assign arrival       = inflight;
  assign push          = arrival && (state == S_PAY);
  assign pop           = out_valid && out_ready;
  assign timeout_hit   = (state != S_HDR) && !arrival && (timer == TMR_W'(TIMEOUT - 1));
  assign parity_bad    = (fifo_data != par);

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? skid[rd_ptr].data : 8'd0;
  assign out_sop   = out_valid && skid[rd_ptr].sop;
  assign out_eop   = out_valid && skid[rd_ptr].eop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_HDR;
    else         state <= state_nxt;
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HDR: if (arrival) state_nxt = (fifo_data[7:2] != 6'd0) ? S_PAY : S_PAR;
      S_PAY: begin
        if (arrival && cnt == 6'd1) state_nxt = S_PAR;
        else if (timeout_hit)       state_nxt = S_HDR;
      end
      S_PAR: if (arrival || timeout_hit) state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inflight     <= 1'b0;
      occ          <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      timer        <= '0;
      cnt          <= 6'd0;
      par          <= 8'd0;
      first        <= 1'b0;
      pkt_addr     <= 2'd0;
      pkt_len      <= 6'd0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
      trunc_err    <= 1'b0;
      pkt_good_cnt <= '0;
      pkt_err_cnt  <= '0;
    end else begin
      inflight   <= fifo_read_enb;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      trunc_err  <= 1'b0;

      if (state == S_HDR || arrival || timeout_hit) timer <= '0;
      else                                          timer <= timer + 1'b1;

      if (push)   wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);

      if (arrival) begin
        unique case (state)
          S_HDR: begin
            pkt_len  <= fifo_data[7:2];
            pkt_addr <= fifo_data[1:0];
            cnt      <= fifo_data[7:2];
            par      <= fifo_data;
            first    <= 1'b1;
          end
          S_PAY: begin
            par   <= par ^ fifo_data;
            cnt   <= cnt - 6'd1;
            first <= 1'b0;
          end
          S_PAR: begin
            pkt_done   <= 1'b1;
            parity_err <= parity_bad;
            if (parity_bad) begin
              if (pkt_err_cnt != '1) pkt_err_cnt <= pkt_err_cnt + 1'b1;
            end else begin
              if (pkt_good_cnt != '1) pkt_good_cnt <= pkt_good_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        // Abandon the packet; bytes already in the skid still drain without a forced eop.
        pkt_done  <= 1'b1;
        trunc_err <= 1'b1;
        if (pkt_err_cnt != '1) pkt_err_cnt <= pkt_err_cnt + 1'b1;
      end
    end
  end

  // NOTE: skid storage is not reset; outputs are gated by out_valid, which comes from the reset occupancy.
  always_ff @(posedge clock) begin
    if (push) skid[wr_ptr] <= '{data: fifo_data, sop: first, eop: (cnt == 6'd1)};
  end

endmodule
